// File: rtl/deserializer.sv
// Collects S serial D-bit words into one D*S-bit word, with word-slip alignment.
// Training lock FSM is compiled in with DESERIALIZER_TRAINING_EN.
module deserializer #(
  parameter int unsigned D = 8,
  parameter int unsigned S = 4,
  parameter logic [D*S-1:0] TRAIN_PATTERN = (D*S)'(32'hA5C3_0FF0),
  parameter int unsigned LOCK_MATCHES = 4
) (
  input  logic           high_speed_clock,
  input  logic           reset_n,
  input  logic [D-1:0]   data_in,
  input  logic           in_valid,
  input  logic           slip_req,
  output logic [D*S-1:0] data_out,
  output logic           out_valid,
  output logic           locked
);

  localparam int unsigned LW = $clog2(S);
  localparam logic [LW-1:0] LAST = LW'(S - 1);

  logic [LW-1:0]  r_lane;
  logic           r_slip_pending;
  logic [D*S-1:0] r_buf;
  logic [D*S-1:0] r_data;
  logic           r_out_valid;

  logic           w_accept;
  logic           w_complete;
  logic           w_strobe;
  logic           w_auto_slip;
  logic [D*S-1:0] w_full;

  // A pending slip or a same-cycle slip request swallows this beat.
  assign w_accept   = in_valid & ~r_slip_pending & ~slip_req;
  assign w_complete = w_accept & (r_lane == LAST);

  always_comb begin
    w_full = r_buf;
    w_full[(S-1)*D +: D] = data_in;
  end

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lane <= '0;
      r_buf  <= '0;
    end else if (w_accept) begin
      r_buf[r_lane*D +: D] <= data_in;
      r_lane <= (r_lane == LAST) ? '0 : r_lane + 1'b1;
    end
  end

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slip_pending <= 1'b0;
    end else if (in_valid) begin
      r_slip_pending <= w_auto_slip;
    end else if (slip_req) begin
      r_slip_pending <= 1'b1;
    end
  end

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_strobe;
      if (w_complete) begin
        r_data <= w_full;
      end
    end
  end

`ifdef DESERIALIZER_TRAINING_EN
  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic       w_hunt_done;
  logic       w_match;
  logic       w_lock_now;

  assign w_hunt_done = (r_state == ST_HUNT) & w_complete;
  assign w_match     = (w_full == TRAIN_PATTERN);
  assign w_lock_now  = w_hunt_done & w_match
                     & (r_cnt == 4'(LOCK_MATCHES - 1));
  assign w_auto_slip = w_hunt_done & ~w_match;
  // The word that achieves lock is itself strobed.
  assign w_strobe    = w_complete & ((r_state == ST_LOCKED) | w_lock_now);
  assign locked      = (r_state == ST_LOCKED);

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_HUNT;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_lock_now) begin
            r_state <= ST_LOCKED;
            r_cnt   <= '0;
          end else if (w_hunt_done) begin
            r_cnt <= w_match ? r_cnt + 1'b1 : '0;
          end
        end
        ST_LOCKED: begin
          if (slip_req) begin
            r_state <= ST_HUNT;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign w_auto_slip = 1'b0;
  assign w_strobe    = w_complete;
  assign locked      = 1'b1;
`endif

  assign data_out  = r_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: queue-based reference model, separate monitor.
// Follows DESERIALIZER_TRAINING_EN the same way as the design.
module tb_deserializer;

  localparam int D  = 8;
  localparam int S  = 4;
  localparam int LM = 2;
  localparam logic [31:0] PAT = 32'hA5C3_0FF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic        in_valid = 1'b0;
  logic        slip_req = 1'b0;
  logic [31:0] data_out;
  logic        out_valid;
  logic        locked;

  deserializer #(
    .D(D), .S(S), .TRAIN_PATTERN(PAT), .LOCK_MATCHES(LM)
  ) dut (
    .high_speed_clock(clk),
    .reset_n(rst_n),
    .data_in(data_in),
    .in_valid(in_valid),
    .slip_req(slip_req),
    .data_out(data_out),
    .out_valid(out_valid),
    .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  m_group[$];
  logic [31:0] exp_q[$];
  bit          m_pend;
  bit          m_locked;
  int          m_cnt;
  logic [31:0] m_last;
  bit          prev_ov;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_group.delete();
    exp_q.delete();
    m_pend = 0;
    m_cnt  = 0;
    m_last = '0;
`ifdef DESERIALIZER_TRAINING_EN
    m_locked = 0;
`else
    m_locked = 1;
`endif
  endtask

  // Word-level view: a slip throws away one future word; every S kept
  // words form one output, first-kept word in the low byte.
  task automatic model_beat(input bit v, input logic [7:0] d, input bit s);
    logic [31:0] w;
`ifdef DESERIALIZER_TRAINING_EN
    if (s && m_locked) begin
      m_locked = 0;
      m_cnt = 0;
    end
`endif
    if (!v) begin
      if (s) m_pend = 1;
    end else if (m_pend || s) begin
      m_pend = 0;
    end else begin
      m_group.push_back(d);
      if (m_group.size() == S) begin
        w = '0;
        for (int i = 0; i < S; i++) w[i*8 +: 8] = m_group[i];
        m_group.delete();
        m_last = w;
`ifdef DESERIALIZER_TRAINING_EN
        if (m_locked) begin
          exp_q.push_back(w);
        end else if (w == PAT) begin
          m_cnt++;
          if (m_cnt == LM) begin
            m_locked = 1;
            m_cnt = 0;
            exp_q.push_back(w);
          end
        end else begin
          m_cnt = 0;
          m_pend = 1;
        end
`else
        exp_q.push_back(w);
`endif
      end
    end
  endtask

  task automatic beat(input bit v, input logic [7:0] d, input bit s);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    slip_req = s;
    @(posedge clk);
    model_beat(v, d, s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 0;
    slip_req = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) beat(1, w[i*8 +: 8], 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(out_valid), 32'd0);
      end else begin
        chk("strobe_data", data_out, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_strobe", 32'(out_valid), 32'd1);
      void'(exp_q.pop_front());
    end
    chk("data_hold", data_out, m_last);
    chk("locked", 32'(locked), 32'(m_locked));
    if (prev_ov) chk("ov_spacing", 32'(out_valid), 32'd0);
    prev_ov = out_valid;
  end

  initial begin
    model_reset();
    prev_ov = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // basic assembly
    send4(32'h44332211);
    #1 chk("basic", data_out, 32'h44332211);

    // gaps between 22 and 33
    do_reset();
    beat(1, 8'h11, 0);
    beat(1, 8'h22, 0);
    repeat (3) beat(0, 8'hEE, 0);
    beat(1, 8'h33, 0);
    beat(1, 8'h44, 0);
    #1 chk("gaps", data_out, 32'h44332211);

    // slip alongside the first word
    do_reset();
    beat(1, 8'h11, 1);
    for (int i = 2; i <= 5; i++) beat(1, 8'(i * 17), 0);
    #1 chk("slip_same", data_out, 32'h55443322);
    for (int i = 6; i <= 8; i++) beat(1, 8'(i * 17), 0);

    // repeated slip while pending drops only one word
    do_reset();
    beat(0, 8'h00, 1);
    beat(0, 8'h00, 1);
    for (int i = 1; i <= 5; i++) beat(1, 8'(i * 17), 0);
    #1 chk("slip_pending", data_out, 32'h55443322);

    // reset mid-group
    do_reset();
    beat(1, 8'h11, 0);
    beat(1, 8'h22, 0);
    do_reset();
    #1 chk("rst_data", data_out, 32'h0);
    send4(32'hDDCCBBAA);
    #1 chk("rst_group", data_out, 32'hDDCCBBAA);

    // training sequence: one extra word, then the pattern repeated
    do_reset();
    beat(1, 8'h5A, 0);
    send4(PAT);
`ifdef DESERIALIZER_TRAINING_EN
    for (int g = 0; g < 3; g++) send4(PAT);
    #1 chk("train_locked", 32'(locked), 32'd1);
    beat(0, 8'h00, 1);
    #1 chk("train_unlock", 32'(locked), 32'd0);
`else
    #1 chk("notrain_shift", data_out, 32'hC30FF05A);
    send4(PAT);
    #1 chk("notrain_shift2", data_out, 32'hC30FF0A5);
`endif

    // randomized traffic, biased toward pattern bytes so lock can occur
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit v;
      bit s;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) d = PAT[(n % 4) * 8 +: 8];
      else d = 8'($urandom);
      beat(v, d, s);
      if (n == 700) do_reset();
    end
    repeat (4) beat(0, 8'h00, 0);
    @(negedge clk);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the word serializer. It collects S consecutive D-bit words arriving on `high_speed_clock` and presents them as one D*S-bit parallel word with a one-cycle valid strobe. It also supports word-slip alignment, so the lane boundary can be moved to match the transmitter's frame phase. It sits at the receive end of the DDR data path, before the slow-domain logic.

## Interface
- `D`, 8, data bitwidth per serial word.
- `S`, 4, deserialization ratio: words per parallel output; S >= 2.
- `TRAIN_PATTERN`, 32'hA5C3_0FF0, expected D*S-bit training word. Used only with training compiled in.
- `LOCK_MATCHES`, 4, number of consecutive pattern matches required for lock. Range 1..15.

Ports:
- `high_speed_clock`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `data_in`  in  D  serial word.
- `in_valid`  in  1  `data_in` is valid this cycle.
- `slip_req`  in  1  single-cycle pulse: discard the next valid word to shift alignment by one lane.
- `data_out`  out  D*S  assembled parallel word, registered.
- `out_valid`  out  1  one-cycle strobe marking a new `data_out`.
- `locked`  out  1  alignment achieved.

## Operation
- Lane counter `lane`, width $clog2(S):
  - Increments on each accepted beat: `in_valid`=1 and no pending slip.
  - Wraps from S-1 to 0 explicitly; S need not be a power of two.
- Assembly buffer (internal, D*S bits):
  - The word accepted at lane k is written to bits [k*D +: D].
  - Lane 0 is the least-significant word. This is the inverse of the serializer's `data_in[k*D +: D]` slicing.
- Output update: when the lane S-1 word is accepted, the full word (buffer plus the incoming word) is written to `data_out`, and `out_valid`=1 on the next cycle.
- `data_out` holds its value between updates; partial assembly never disturbs it.
- Slip handling:
  - `slip_req` sets `slip_pending`.
  - The next beat with `in_valid`=1 is dropped: not stored, `lane` unchanged. Then `slip_pending` clears.
  - A `slip_req` that arrives while a slip is pending is absorbed, not queued.
  - When `slip_req` and `in_valid` are high in the same cycle, that same-cycle word is the one dropped.
- `in_valid`=0 freezes `lane`, the buffer and `slip_pending`. Gaps of any length are legal.

## Timing
- Reset values: `data_out`=0, `out_valid`=0, `lane`=0, `slip_pending`=0, buffer=0, lock state HUNT, match count 0. `locked` resets to 0 with training and is constant 1 without it.
- Latency: the last word of a group is accepted at edge N, and `data_out`/`out_valid` update at edge N.
- `out_valid` is never high for two consecutive cycles unless S=... (impossible; minimum spacing is S cycles).
- Reset asserted mid-group: the partial group is discarded. The first valid word after reset release goes to lane 0.

## Configuration
- Macro: `DESERIALIZER_TRAINING_EN`.
- **Defined:** two-state FSM, HUNT and LOCKED.
  - **HUNT:** each completed word is compared with `TRAIN_PATTERN`.
    - A match increments the match count. Reaching `LOCK_MATCHES` goes to LOCKED, sets `locked`=1 and clears the count.
    - A mismatch clears the count and raises an internal slip, identical to `slip_req`.
  - **LOCKED:** external `slip_req` returns to HUNT (`locked`=0, count=0) and also performs the slip.
  - `out_valid` is gated: it strobes only in LOCKED. `data_out` still updates in HUNT.
  - The transition to LOCKED takes effect on the same edge as the completing word, so that word does strobe `out_valid`.
- **Undefined:** no FSM and no comparator. `locked` is tied to 1, every completed word strobes `out_valid`, and only external `slip_req` slips. `TRAIN_PATTERN` and `LOCK_MATCHES` are ignored.

## Test plan
All scenarios use D=8, S=4.
1. **Basic assembly.** Reset, then continuous valid words 11,22,33,44 → `data_out`=32'h44332211, `out_valid` a single 1-cycle pulse, at the edge accepting 44.
2. **Input gaps.** Same words with `in_valid` dropped for 3 cycles between 22 and 33 → same output. `data_out` keeps its previous value during the gaps.
3. **Slip.** Stream 11,22,33,44,55,66,77,88 with `slip_req` pulsed alongside 11 → first output 32'h55443322; a repeated `slip_req` while pending has no extra effect.
4. **Reset mid-group.** Send 11,22, pulse `reset_n` low, then send AA,BB,CC,DD → `data_out` 0 during reset, then 32'hDDCCBBAA; `out_valid` low throughout reset.
5. **Training lock** (macro defined, `LOCK_MATCHES`=2). Send the pattern words F0,0F,C3,A5 repeated, preceded by one extra word → auto-slip once. Then `locked` rises on the second matching word, with the first `out_valid` on that same edge. A later `slip_req` drops `locked` on the next edge.
6. **Training compiled out.** Repeat scenario 5 → `locked` is constantly 1, every group strobes `out_valid`, and there is no auto-slip, so words stay misaligned: 32'hC30FF0xx pattern shifted.
